gf_inv_seq: RTL and testbench

//  Iterative GF(2^8) multiplicative inverse: the stage directly upstream of s_box.
//  Its output feeds s_box.b, which applies the affine transform to complete SubBytes.

---
 rtl/gf_inv_seq.sv | 155 +++++++++++++++
 tb/tb_gf_inv_seq.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/gf_inv_seq.sv
// -----------------------------------------------------------------------------
// gf_inv_seq
// Iterative GF(2^8) multiplicative inverse, inv(x) = x^254, computed by
// square-and-multiply with one GF square plus one GF multiply per cycle.
// Sits directly upstream of s_box, whose affine transform completes SubBytes.
// One operand is in flight at a time; a valid/ready handshake on both sides
// lets several AES-256 control FSMs share a single unit.
//
// Parameters
//   POLY       low byte of the reduction polynomial (x^8+x^4+x^3+x+1 -> 8'h1B)
//
// Ports
//   clk        in   1  clock, all state updates on the rising edge
//   rst        in   1  synchronous, active-high reset
//   in_valid   in   1  in_byte holds an operand
//   in_ready   out  1  unit idle and able to accept an operand (registered)
//   in_byte    in   8  operand x, sampled only on the accepting edge
//   out_valid  out  1  out_byte holds inv(x) (registered)
//   out_ready  in   1  consumer takes out_byte this cycle
//   out_byte   out  8  inv(x), inv(0) = 0 (registered)
// -----------------------------------------------------------------------------
module gf_inv_seq #(
    parameter logic [7:0] POLY = 8'h1B
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] in_byte,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] out_byte
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    // Shift-and-add GF(2^8) multiply; reduce whenever bit 7 is shifted out.
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] prod;
        logic [7:0] addend;
        prod   = 8'h00;
        addend = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) begin
                prod = prod ^ addend;
            end else begin
                prod = prod;
            end
            if (addend[7]) begin
                addend = {addend[6:0], 1'b0} ^ POLY;
            end else begin
                addend = {addend[6:0], 1'b0};
            end
        end
        return prod;
    endfunction

    state_t     state_q, state_d;
    logic [7:0] sq_q, sq_d;
    logic [7:0] acc_q, acc_d;
    logic [2:0] step_q, step_d;
    logic       in_ready_q, in_ready_d;
    logic       out_valid_q, out_valid_d;
    logic [7:0] out_byte_q, out_byte_d;

    logic [7:0] sq_sq_s;
    logic [7:0] acc_mul_s;

    // Datapath: next square of the running power and the accumulator times it.
    always_comb begin
        sq_sq_s   = gmul(sq_q, sq_q);
        acc_mul_s = gmul(acc_q, sq_sq_s);
    end

    // Next-state and next-output logic for the IDLE/CALC/DONE sequencer.
    always_comb begin
        state_d     = state_q;
        sq_d        = sq_q;
        acc_d       = acc_q;
        step_d      = step_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        out_byte_d  = out_byte_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    sq_d       = in_byte;
                    acc_d      = 8'h01;
                    step_d     = 3'd0;
                    in_ready_d = 1'b0;
                    state_d    = CALC;
                end else begin
                    in_ready_d = 1'b1;
                end
            end
            CALC: begin
                // Step n folds x^(2^(n+1)) into acc; after step 6 acc = x^254.
                sq_d   = sq_sq_s;
                acc_d  = acc_mul_s;
                step_d = step_q + 3'd1;
                if (step_q == 3'd6) begin
                    out_byte_d  = acc_mul_s;
                    out_valid_d = 1'b1;
                    state_d     = DONE;
                end else begin
                    state_d = CALC;
                end
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    state_d     = IDLE;
                end else begin
                    state_d = DONE;
                end
            end
            default: begin
                state_d     = IDLE;
                in_ready_d  = 1'b1;
                out_valid_d = 1'b0;
            end
        endcase
    end

    // State and output registers; reset discards any operand in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            sq_q        <= 8'h00;
            acc_q       <= 8'h00;
            step_q      <= 3'd0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_byte_q  <= 8'h00;
        end else begin
            state_q     <= state_d;
            sq_q        <= sq_d;
            acc_q       <= acc_d;
            step_q      <= step_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            out_byte_q  <= out_byte_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_byte  = out_byte_q;

endmodule

// File: tb/tb_gf_inv_seq.sv
module tb_gf_inv_seq;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_byte;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_byte;

    int errors;
    int checks;
    bit chk_en;

    gf_inv_seq #(.POLY(8'h1B)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_byte  (in_byte),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_byte (out_byte)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference multiply: full carry-less product, then polynomial long division.
    function automatic logic [7:0] mul_ref(input logic [7:0] a, input logic [7:0] b);
        logic [14:0] p;
        logic [14:0] m;
        p = 15'h0000;
        for (int i = 0; i < 8; i++)
            if (b[i]) p = p ^ (15'({7'h00, a}) << i);
        for (int bit_i = 14; bit_i >= 8; bit_i--) begin
            m = 15'h011B;
            if (p[bit_i]) p = p ^ (m << (bit_i - 8));
        end
        return p[7:0];
    endfunction

    // Reference inverse by exhaustive search.
    function automatic logic [7:0] inv_ref(input logic [7:0] x);
        logic [7:0] y;
        if (x == 8'h00) return 8'h00;
        for (int i = 1; i < 256; i++) begin
            y = 8'(i);
            if (mul_ref(x, y) == 8'h01) return y;
        end
        return 8'h00;
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] v, input int n);
        logic [15:0] t;
        t = {v, v} << n;
        return t[15:8];
    endfunction

    function automatic logic [7:0] affine(input logic [7:0] b);
        return b ^ rotl(b, 1) ^ rotl(b, 2) ^ rotl(b, 3) ^ rotl(b, 4) ^ 8'h63;
    endfunction

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction-level model: expected outputs after each rising edge.
    bit         m_ir, m_ov, m_busy;
    logic [7:0] m_ob, m_res;
    int         m_cnt;
    always @(posedge clk) begin
        if (rst) begin
            m_ir = 1'b1; m_ov = 1'b0; m_ob = 8'h00; m_busy = 1'b0; m_cnt = 0;
        end else if (m_ir) begin
            if (in_valid) begin
                m_ir = 1'b0; m_busy = 1'b1; m_cnt = 0; m_res = inv_ref(in_byte);
            end
        end else if (m_busy) begin
            m_cnt++;
            if (m_cnt == 7) begin
                m_busy = 1'b0; m_ov = 1'b1; m_ob = m_res;
            end
        end else if (m_ov && out_ready) begin
            m_ov = 1'b0; m_ir = 1'b1;
        end
    end

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            check("in_ready", {7'h00, in_ready}, {7'h00, m_ir});
            check("out_valid", {7'h00, out_valid}, {7'h00, m_ov});
            check("out_byte", out_byte, m_ob);
        end
    end

    // One transaction: present x, wait for the result, optionally stall.
    task automatic op(input logic [7:0] x, input int stall, input bit wiggle,
                      output logic [7:0] res, output int lat);
        int n;
        n = 0;
        while (!in_ready && n < 50) begin @(negedge clk); n++; end
        if (n >= 50) begin
            errors++;
            $display("FAIL in_ready_timeout: got 0 expected 1");
        end
        in_valid  = 1'b1;
        in_byte   = x;
        out_ready = (stall == 0);
        @(negedge clk);
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 20) begin
            if (wiggle) begin
                in_valid = 1'($urandom_range(0, 1));
                in_byte  = 8'($urandom);
            end
            @(negedge clk);
            lat++;
        end
        in_valid = 1'b0;
        if (lat >= 20) begin
            errors++;
            $display("FAIL out_valid_timeout: got 0 expected 1");
        end
        res = out_byte;
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            check("stall_valid", {7'h00, out_valid}, 8'h01);
            check("stall_ready", {7'h00, in_ready}, 8'h00);
            check("stall_byte", out_byte, res);
        end
        out_ready = 1'b1;
        @(negedge clk);
        check("post_xfer_valid", {7'h00, out_valid}, 8'h00);
        check("post_xfer_ready", {7'h00, in_ready}, 8'h01);
    endtask

    logic [7:0] known_in  [5] = '{8'h53, 8'h01, 8'h02, 8'hFF, 8'h00};
    logic [7:0] known_out [5] = '{8'hCA, 8'h01, 8'h8D, 8'h1C, 8'h00};

    initial begin
        logic [7:0] res;
        int         lat;
        logic [7:0] xv;
        errors = 0; checks = 0; chk_en = 1'b0;
        rst = 1'b1; in_valid = 1'b0; in_byte = 8'h00; out_ready = 1'b1;

        // Reset
        repeat (2) @(negedge clk);
        check("rst_in_ready", {7'h00, in_ready}, 8'h01);
        check("rst_out_valid", {7'h00, out_valid}, 8'h00);
        check("rst_out_byte", out_byte, 8'h00);
        rst = 1'b0;
        chk_en = 1'b1;

        // Known values and latency
        for (int i = 0; i < 5; i++) begin
            op(known_in[i], 0, 1'b0, res, lat);
            check("known_val", res, known_out[i]);
            check("latency", 8'(lat), 8'd7);
        end

        // Exhaustive sweep with the product identity and chained affine
        for (int i = 0; i < 256; i++) begin
            xv = 8'(i);
            op(xv, 0, 1'b0, res, lat);
            if (xv == 8'h00) check("inv_zero", res, 8'h00);
            else check("inv_prod", mul_ref(xv, res), 8'h01);
            if (xv == 8'h00) check("sbox_00", affine(res), 8'h63);
            if (xv == 8'h53) check("sbox_53", affine(res), 8'hED);
        end

        // Backpressure
        op(8'h53, 20, 1'b0, res, lat);
        check("bp_val", res, 8'hCA);

        // Input wiggle during CALC, random operands and stalls
        for (int i = 0; i < 40; i++) begin
            xv = 8'($urandom);
            op(xv, int'($urandom_range(0, 3)), 1'b1, res, lat);
            check("rand_val", res, inv_ref(xv));
        end

        // Reset mid-CALC
        in_valid = 1'b1; in_byte = 8'h53;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_ready", {7'h00, in_ready}, 8'h01);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("midrst_noval", {7'h00, out_valid}, 8'h00);
        end
        op(8'h02, 0, 1'b0, res, lat);
        check("midrst_next", res, 8'h8D);

        repeat (2) @(negedge clk);
        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
